// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with optional grant locking.
// The grant is purely combinational from the request vector and the stored
// priority pointer. A granted requester can hold its grant across cycles by
// asserting lock_i. Priority then rotates to the index after the released grant.
module round_robin_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic                       allow_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       lock_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
    output logic                       gnt_valid_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

    logic             effLocked;
    logic             scanHit;
    logic [IDX_W-1:0] scanIdx;
    logic             selValid;
    logic [IDX_W-1:0] selIdx;

    // Advance an index by one, wrapping at NUM_REQ so non-power-of-two sizes stay in range
    function automatic logic [IDX_W-1:0] incIdx(input logic [IDX_W-1:0] x);
        return (x == IDX_W'(NUM_REQ - 1)) ? '0 : x + 1'b1;
    endfunction

    // Rotating priority scan: first set request starting at ptr_q and wrapping around
    always_comb begin
        int cand;
        scanHit = 1'b0;
        scanIdx = '0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!scanHit && req_i[IDX_W'(cand)]) begin
                scanHit = 1'b1;
                scanIdx = IDX_W'(cand);
            end
        end
    end

    // A lock only takes effect while its owner is still requesting
    always_comb begin
        effLocked = (state_q == LOCKED) && req_i[lock_idx_q];
        selIdx    = effLocked ? lock_idx_q : scanIdx;
        selValid  = allow_i && (effLocked || scanHit);
    end

    // Decode the selected index into the one-hot grant and its companions
    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_o[i] = selValid && (selIdx == IDX_W'(i));
        end
        gnt_idx_o   = selValid ? selIdx : '0;
        gnt_valid_o = |gnt_o;
    end

    // Next-state: only an actual grant moves the pointer or the lock state
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        if (selValid) begin
            if (effLocked) begin
                if (!lock_i) begin
                    state_d = IDLE;
                    ptr_d   = incIdx(lock_idx_q);
                end
            end else if (lock_i) begin
                state_d    = LOCKED;
                lock_idx_d = scanIdx;
            end else begin
                state_d = IDLE;
                ptr_d   = incIdx(scanIdx);
            end
        end
    end

    // State registers with asynchronous active-low reset back to fixed priority
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 The block SHALL take parameter NUM_REQ, default 4, the number of requesters; legal range 2..64, any value, not only powers of two.
REQ-002 The block SHALL define localparam IDX_W = $clog2(NUM_REQ), the width of the grant index.
REQ-003 Port clk_i, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port arst_ni, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port allow_i, input, 1 bit, SHALL be the global grant enable; when it is 0 no grant is issued.
REQ-006 Port req_i, input, NUM_REQ bits, SHALL carry the request vector, with bit i belonging to requester i.
REQ-007 Port lock_i, input, 1 bit, SHALL request that the current grant be held on following cycles.
REQ-008 Port gnt_o, output, NUM_REQ bits, SHALL be the one-hot grant vector, or all zero when nothing is granted.
REQ-009 Port gnt_idx_o, output, IDX_W bits, SHALL be the index of the granted requester, and 0 when nothing is granted.
REQ-010 Port gnt_valid_o, output, 1 bit, SHALL equal |gnt_o.

Function
REQ-011 Internal state SHALL be ptr_q (IDX_W bits, the highest-priority index), state_q (IDLE or LOCKED), and lock_idx_q (IDX_W bits).
REQ-012 Grant SHALL be combinational, zero-latency, and in the same cycle as req_i, allow_i and lock_i; there SHALL be no registered outputs.
REQ-013 When allow_i=0: gnt_o=0, gnt_valid_o=0, gnt_idx_o=0, and all state SHALL hold.
REQ-014 The effective mode SHALL be LOCKED only when state_q=LOCKED and req_i[lock_idx_q]=1; in every other case the effective mode is IDLE.
REQ-015 In effective IDLE with allow_i=1, the grant SHALL go to the first set bit of req_i, scanning ptr_q, ptr_q+1, ... NUM_REQ-1, 0, ... ptr_q-1.
REQ-016 In effective LOCKED with allow_i=1, the grant SHALL be onehot(lock_idx_q), regardless of ptr_q and of the other requests.
REQ-017 When req_i=0 with allow_i=1, there SHALL be no grant and state SHALL hold.
REQ-018 Edge, effective IDLE, grant g, lock_i=0: ptr_q SHALL become (g+1) mod NUM_REQ and state_q SHALL become IDLE.
REQ-019 Edge, effective IDLE, grant g, lock_i=1: state_q SHALL become LOCKED, lock_idx_q SHALL become g, and ptr_q SHALL hold.
REQ-020 Edge, effective LOCKED, lock_i=1: all state SHALL hold.
REQ-021 Edge, effective LOCKED, lock_i=0: state_q SHALL become IDLE and ptr_q SHALL become (lock_idx_q+1) mod NUM_REQ.
REQ-022 Pointer wrap SHALL be modulo NUM_REQ: index NUM_REQ-1 leads to 0, and ptr_q SHALL never reach a value >= NUM_REQ.
REQ-023 Outputs SHALL contain no X when inputs are known; gnt_o SHALL never have more than one bit set.

Reset
REQ-024 While arst_ni=0: ptr_q=0, state_q=IDLE and lock_idx_q=0, applied immediately and asynchronously, including when reset arrives mid-lock.
REQ-025 During reset, outputs SHALL follow REQ-013 and REQ-015 with ptr_q=0, i.e. fixed priority with index 0 highest.
REQ-026 Reset release SHALL be safe at any clock phase; the first state update occurs at the first rising edge after deassertion.

Verification (NUM_REQ=4)
REQ-027 Post-reset, allow_i=1, req_i=1111, lock_i=0 for 5 cycles -> gnt_o SHALL be 0001, 0010, 0100, 1000, 0001.
REQ-028 Wrap: ptr_q=2 (after a grant to 1), req_i=0011 -> gnt_o SHALL be 0001 and gnt_idx_o 0, and next ptr_q SHALL be 1.
REQ-029 allow_i=0, req_i=1111 for 3 cycles -> gnt_o SHALL be 0000 and gnt_valid_o 0; afterwards allow_i=1 SHALL grant the same index that was pending before.
REQ-030 Post-reset, req_i=1111, lock_i=1 for 3 cycles then 0 -> gnt_o SHALL be 0001 for 4 cycles, then 0010.
REQ-031 LOCKED on 0 with lock_i=1, req_i drops to 1110 -> gnt_o SHALL be 0010 in the same cycle, the block SHALL relock on 1, and ptr_q SHALL be unchanged.
REQ-032 arst_ni pulsed low while LOCKED on 2 -> state SHALL become IDLE and ptr_q 0; req_i=1111 SHALL then give gnt_o=0001 immediately.
REQ-033 Random stimulus of 1000+ cycles SHALL be checked against a reference model: one-hot grant, no grant while allow_i=0, and every persistent requester served within NUM_REQ grants while unlocked.
